// File: rtl/word_pack_pkg.sv
// Shared definitions for the word packer / unpacker pair: width ratio
// helpers, the chunk-count type and the unpacker state encoding.
package word_pack_pkg;

    // Number of narrow chunks that make up one wide word.
    function automatic int ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Width of a counter able to hold 0..ratio inclusive.
    function automatic int chunk_cnt_width(input int in_w, input int out_w);
        return $clog2(ratio(in_w, out_w) + 1);
    endfunction

    // Default geometry: 32-bit words split into bytes.
    localparam int DEFAULT_IN_W  = 32;
    localparam int DEFAULT_OUT_W = 8;
    localparam int DEFAULT_RATIO = ratio(DEFAULT_IN_W, DEFAULT_OUT_W);
    localparam int CHUNK_CNT_W   = chunk_cnt_width(DEFAULT_IN_W, DEFAULT_OUT_W);

    // Chunk-count type for the default geometry.
    typedef logic [CHUNK_CNT_W-1:0] chunk_cnt_t;

    // IDLE: no word held. SHIFT: a word is held and a chunk is on the output.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } unpack_state_e;

endpackage

// File: rtl/word_unpacker.sv
// Wide-to-narrow width converter. One IN_W word is accepted per handshake and
// is replayed as up to IN_W/OUT_W chunks on a valid/ready stream; the final
// chunk of each word carries out_last. A new word can be taken in the same
// cycle the last chunk of the previous word leaves, so back-to-back words
// stream without a bubble.
module word_unpacker
    import word_pack_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int RATIO    = ratio(IN_W, OUT_W),
    localparam int CNT_W    = chunk_cnt_width(IN_W, OUT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [CNT_W-1:0] in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);

    // Geometry check: the word must split into a whole number of chunks,
    // and at least two of them, otherwise this block has nothing to do.
    if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_bad_cfg
        $error("word_unpacker: IN_W must be an exact multiple of OUT_W with IN_W/OUT_W >= 2");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_RATIO = CNT_W'(RATIO);

    // State flops and their next-state values.
    unpack_state_e    state_q;
    unpack_state_e    state_d;
    logic [IN_W-1:0]  sreg_q;
    logic [IN_W-1:0]  sreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_q;
    logic             last_d;

    // Handshake decode.
    logic             out_valid_s;
    logic             xfer_s;
    logic             word_done_s;
    logic             in_ready_s;
    logic             load_s;
    logic [CNT_W-1:0] len_eff_s;
    logic [IN_W-1:0]  sreg_shifted_s;

    // A word is held exactly while in SHIFT, so that state alone is out_valid.
    assign out_valid_s = (state_q == SHIFT);
    assign xfer_s      = out_valid_s && out_ready;
    assign word_done_s = xfer_s && last_q;

    // Ready when empty, or when the last chunk of the held word is leaving
    // right now; this combinational path from out_ready removes the bubble.
    assign in_ready_s  = (state_q == IDLE) || word_done_s;
    assign load_s      = in_valid && in_ready_s;

    // Chunk count requested for the incoming word: 0 and any out-of-range
    // value mean a full word.
    always_comb begin
        len_eff_s = CNT_RATIO;
        if ((in_len == CNT_ZERO) || (in_len > CNT_RATIO)) begin
            len_eff_s = CNT_RATIO;
        end else begin
            len_eff_s = in_len;
        end
    end

    // Move the next chunk into the output window of the shift register.
    always_comb begin
        sreg_shifted_s = sreg_q;
        if (MSB_FIRST) begin
            sreg_shifted_s = sreg_q << OUT_W;
        end else begin
            sreg_shifted_s = sreg_q >> OUT_W;
        end
    end

    // Shift register next value: capture on load, advance on each transfer.
    always_comb begin
        sreg_d = sreg_q;
        if (load_s) begin
            sreg_d = in_data;
        end else if (xfer_s) begin
            sreg_d = sreg_shifted_s;
        end else begin
            sreg_d = sreg_q;
        end
    end

    // Remaining-chunk counter and the registered last flag that tracks it.
    // The flag is precomputed so out_last is a flop, not a compare.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (load_s) begin
            cnt_d  = len_eff_s;
            last_d = (len_eff_s == CNT_ONE);
        end else if (xfer_s) begin
            cnt_d  = cnt_q - CNT_ONE;
            last_d = (cnt_q == CNT_TWO);
        end else begin
            cnt_d  = cnt_q;
            last_d = last_q;
        end
    end

    // FSM next state; a load wins over the end of the previous word so a
    // zero-bubble follow-on word keeps the machine in SHIFT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_s) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (load_s) begin
                    state_d = SHIFT;
                end else if (word_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift register storage; reset clears it so out_data reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= {IN_W{1'b0}};
        end else begin
            sreg_q <= sreg_d;
        end
    end

    // Remaining-chunk counter and last flag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_ZERO;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    // FSM state storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The output chunk is always the window at the output end of the register.
    if (MSB_FIRST) begin : g_msb_out
        assign out_data = sreg_q[IN_W-1 -: OUT_W];
    end else begin : g_lsb_out
        assign out_data = sreg_q[OUT_W-1:0];
    end

    assign out_valid = out_valid_s;
    assign out_last  = last_q && out_valid_s;
    assign in_ready  = in_ready_s;

endmodule

// File: tb/tb_word_unpacker.sv
// Bench for word_unpacker: one MSB-first and one LSB-first instance share the
// same stimulus; a queue-based model of pending chunks predicts every output.
module tb_word_unpacker;

    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [2:0]  in_len;
    logic        out_ready;

    logic        in_ready_m, out_valid_m, out_last_m;
    logic [7:0]  out_data_m;
    logic        in_ready_l, out_valid_l, out_last_l;
    logic [7:0]  out_data_l;

    always #5 clk = ~clk;

    word_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data), .in_len(in_len),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m), .out_last(out_last_m)
    );

    word_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data), .in_len(in_len),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l), .out_last(out_last_l)
    );

    typedef struct {
        logic [7:0] dm;
        logic [7:0] dl;
        bit         last;
    } chunk_t;

    chunk_t     q[$];
    logic [7:0] log_dm[$];
    logic [7:0] log_dl[$];
    bit         log_last[$];
    bit         log_rdy[$];
    int         log_cyc[$];
    int         acc_cyc[$];
    logic [7:0] stall_d[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: number of chunks a word yields, and chunk idx in either order.
    function automatic int model_len(input logic [2:0] len);
        return ((len == 3'd0) || (len > 3'd4)) ? RATIO : int'(len);
    endfunction

    function automatic logic [7:0] model_chunk(input logic [31:0] d, input int idx, input bit msb);
        return msb ? d[31-8*idx -: 8] : d[8*idx +: 8];
    endfunction

    function automatic void push_word(input logic [31:0] d, input logic [2:0] len);
        chunk_t c;
        int n;
        n = model_len(len);
        for (int i = 0; i < n; i++) begin
            c.dm   = model_chunk(d, i, 1'b1);
            c.dl   = model_chunk(d, i, 1'b0);
            c.last = (i == n - 1);
            q.push_back(c);
        end
    endfunction

    // Per-cycle compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin : cmp
        bit exp_v;
        bit exp_r;
        cyc++;
        if (!rst_n) begin
            q.delete();
            chk("rst_valid_m", 32'(out_valid_m), 32'd0);
            chk("rst_valid_l", 32'(out_valid_l), 32'd0);
            chk("rst_last_m",  32'(out_last_m),  32'd0);
            chk("rst_data_m",  32'(out_data_m),  32'd0);
            chk("rst_data_l",  32'(out_data_l),  32'd0);
            chk("rst_ready_m", 32'(in_ready_m),  32'd1);
        end else begin
            exp_v = (q.size() != 0);
            exp_r = !exp_v || (out_ready && (q.size() == 1));
            chk("valid_m", 32'(out_valid_m), 32'(exp_v));
            chk("valid_l", 32'(out_valid_l), 32'(exp_v));
            chk("ready_m", 32'(in_ready_m),  32'(exp_r));
            chk("ready_l", 32'(in_ready_l),  32'(exp_r));
            if (exp_v) begin
                chk("data_m", 32'(out_data_m), 32'(q[0].dm));
                chk("data_l", 32'(out_data_l), 32'(q[0].dl));
                chk("last_m", 32'(out_last_m), 32'(q[0].last));
                chk("last_l", 32'(out_last_l), 32'(q[0].last));
            end
            if (out_valid_m && !out_ready) stall_d.push_back(out_data_m);
            if (exp_v && out_ready) begin
                log_dm.push_back(out_data_m);
                log_dl.push_back(out_data_l);
                log_last.push_back(out_last_m);
                log_rdy.push_back(in_ready_m);
                log_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (in_valid && exp_r) begin
                acc_cyc.push_back(cyc);
                push_word(in_data, in_len);
            end
        end
    end

    task automatic clear_logs();
        log_dm.delete(); log_dl.delete(); log_last.delete();
        log_rdy.delete(); log_cyc.delete(); acc_cyc.delete(); stall_d.delete();
    endtask

    // Present a word and hold it until it is taken; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic [2:0] len);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = len;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (in_ready_m) break;
            k++;
        end
        chk("send_accept_timeout", 32'(k < 50), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((q.size() != 0) && (k < 50)) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        chk("drain_done", 32'(q.size()), 32'd0);
    endtask

    // Compare the transfer log with an expected list; chunk i is eb[63-8*i -: 8].
    task automatic chk_seq(input string name, input logic [63:0] eb, input int n,
                           input logic [7:0] lm, input bit lsb_dut);
        chk({name, "_count"}, 32'(log_dm.size()), 32'(n));
        for (int i = 0; (i < n) && (i < log_dm.size()); i++) begin
            chk($sformatf("%s_data%0d", name, i),
                32'(lsb_dut ? log_dl[i] : log_dm[i]), 32'(eb[63-8*i -: 8]));
            chk($sformatf("%s_last%0d", name, i), 32'(log_last[i]), 32'(lm[i]));
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_len = 3'd0; out_ready = 1'b0;

        // Reset with random inputs.
        repeat (4) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom); in_data = $urandom; in_len = 3'($urandom); out_ready = 1'($urandom);
        end
        chk("t1_out_valid", 32'(out_valid_m), 32'd0);
        chk("t1_out_last",  32'(out_last_m),  32'd0);
        chk("t1_out_data",  32'(out_data_m),  32'd0);
        chk("t1_in_ready",  32'(in_ready_m),  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pin the model itself against hand values.
        chk("model_len0", 32'(model_len(3'd0)), 32'd4);
        chk("model_len5", 32'(model_len(3'd5)), 32'd4);
        chk("model_len2", 32'(model_len(3'd2)), 32'd2);
        chk("model_msb1", 32'(model_chunk(32'hA1B2C3D4, 1, 1'b1)), 32'h000000B2);
        chk("model_lsb0", 32'(model_chunk(32'hCAFEF00D, 0, 1'b0)), 32'h0000000D);

        // Full word, one chunk per cycle, first chunk one cycle after accept.
        clear_logs();
        send_word(32'hA1B2C3D4, 3'd0);
        wait_drain();
        chk_seq("t2", 64'hA1B2C3D4_00000000, 4, 8'b0000_1000, 1'b0);
        if (log_cyc.size() == 4 && acc_cyc.size() == 1) begin
            chk("t2_latency", 32'(log_cyc[0] - acc_cyc[0]), 32'd1);
            for (int i = 1; i < 4; i++) chk("t2_consecutive", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end

        // Back-to-back words with no bubble.
        clear_logs();
        send_word(32'h11223344, 3'd0);
        send_word(32'h55667788, 3'd0);
        wait_drain();
        chk_seq("t3", 64'h11223344_55667788, 8, 8'b1000_1000, 1'b0);
        if (log_cyc.size() == 8 && acc_cyc.size() == 2) begin
            for (int i = 1; i < 8; i++) chk("t3_no_bubble", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
            chk("t3_accept_on_44", 32'(acc_cyc[1]), 32'(log_cyc[3]));
        end

        // Backpressure on chunk 2.
        clear_logs();
        send_word(32'hDEADBEEF, 3'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        chk_seq("t4", 64'hDEADBEEF_00000000, 4, 8'b0000_1000, 1'b0);
        chk("t4_stall_count", 32'(stall_d.size()), 32'd3);
        foreach (stall_d[i]) chk("t4_stall_data", 32'(stall_d[i]), 32'h000000AD);

        // Short words.
        clear_logs();
        send_word(32'hCAFEF00D, 3'd2);
        wait_drain();
        chk_seq("t5a_msb", 64'hCAFE0000_00000000, 2, 8'b0000_0010, 1'b0);
        chk_seq("t5a_lsb", 64'h0DF00000_00000000, 2, 8'b0000_0010, 1'b1);
        chk("t5a_ready_after", 32'(in_ready_m), 32'd1);
        clear_logs();
        send_word(32'hCAFEF00D, 3'd1);
        wait_drain();
        chk_seq("t5b", 64'hCA000000_00000000, 1, 8'b0000_0001, 1'b0);
        if (log_rdy.size() == 1) chk("t5b_ready_in_xfer", 32'(log_rdy[0]), 32'd1);
        clear_logs();
        send_word(32'h01234567, 3'd6);
        wait_drain();
        chk_seq("t5c_len6", 64'h01234567_00000000, 4, 8'b0000_1000, 1'b0);

        // Reset in the middle of a word.
        clear_logs();
        send_word(32'h01020304, 3'd0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid_m), 32'd0);
        chk("t6_async_data",  32'(out_data_m),  32'd0);
        chk("t6_async_last",  32'(out_last_m),  32'd0);
        chk("t6_async_ready", 32'(in_ready_m),  32'd1);
        chk_seq("t6_partial", 64'h01000000_00000000, 1, 8'b0000_0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        send_word(32'hAABBCCDD, 3'd0);
        wait_drain();
        chk_seq("t6_after", 64'hAABBCCDD_00000000, 4, 8'b0000_1000, 1'b0);

        // Random traffic, random backpressure, occasional reset pulses.
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_len    = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
